// File: rtl/enigma_pkg.sv
// Shared constants for the Enigma datapath: alphabet size, plugboard depth,
// one-hot letter codes and the plugboard state encoding.
package enigma_pkg;

  localparam int unsigned ALPHA_DEFAULT = 26;
  localparam int unsigned PAIRS_DEFAULT = 10;

  // One-hot letter codes, bit 0 = 'A'
  localparam logic [ALPHA_DEFAULT-1:0] LTR_A = 26'b1 << 0;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_B = 26'b1 << 1;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_C = 26'b1 << 2;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_D = 26'b1 << 3;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_E = 26'b1 << 4;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_F = 26'b1 << 5;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_G = 26'b1 << 6;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_H = 26'b1 << 7;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_I = 26'b1 << 8;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_J = 26'b1 << 9;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_K = 26'b1 << 10;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_L = 26'b1 << 11;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_M = 26'b1 << 12;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_N = 26'b1 << 13;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_O = 26'b1 << 14;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_P = 26'b1 << 15;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_Q = 26'b1 << 16;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_R = 26'b1 << 17;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_S = 26'b1 << 18;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_T = 26'b1 << 19;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_U = 26'b1 << 20;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_V = 26'b1 << 21;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_W = 26'b1 << 22;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_X = 26'b1 << 23;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_Y = 26'b1 << 24;
  localparam logic [ALPHA_DEFAULT-1:0] LTR_Z = 26'b1 << 25;

  // Plugboard state encoding
  typedef logic [0:0] state_t;
  localparam state_t ST_LOAD = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/onehot_check.sv
// Combinational one-hot detector: high when exactly one bit of letter is set.
module onehot_check #(
  parameter int unsigned ALPHA = 26
) (
  input  logic [ALPHA-1:0] letter,
  output logic             is_onehot
);

  // Nonzero and clearing the lowest set bit leaves nothing
  always_comb begin
    is_onehot = (letter != '0) && ((letter & (letter - ALPHA'(1))) == '0);
  end

endmodule

// File: rtl/stecker_board.sv
// Enigma plugboard: loads up to MAX_PAIRS symmetric swaps through a ready/valid
// port, then locks. Lookups are registered (one-cycle latency) in either state.
module stecker_board
  import enigma_pkg::*;
#(
  parameter int unsigned ALPHA     = ALPHA_DEFAULT,
  parameter int unsigned MAX_PAIRS = PAIRS_DEFAULT
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [ALPHA-1:0]               cfg_a,
  input  logic [ALPHA-1:0]               cfg_b,
  input  logic                           cfg_lock,
  input  logic                           cfg_clear,
  output logic                           cfg_err,
  output logic [$clog2(MAX_PAIRS+1)-1:0] pair_count,
  output logic                           locked,
  input  logic                           in_valid,
  input  logic [ALPHA-1:0]               in_letter,
  output logic                           out_valid,
  output logic [ALPHA-1:0]               out_letter,
  output logic                           out_err
);

  localparam int unsigned CW = $clog2(MAX_PAIRS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PAIRS);

  state_t             state_q, state_d;
  logic [ALPHA-1:0]   slot_a_q [MAX_PAIRS];
  logic [ALPHA-1:0]   slot_b_q [MAX_PAIRS];
  logic [ALPHA-1:0]   used_q;
  logic [CW-1:0]      count_q;
  logic               cfg_err_q;
  logic               out_valid_q;
  logic [ALPHA-1:0]   out_letter_q;
  logic               out_err_q;

  logic               a_onehot, b_onehot, in_onehot;
  logic               offer, reject, write_en;
  logic [ALPHA-1:0]   partner;
  logic               hit;
  logic [ALPHA-1:0]   lookup_letter;

  onehot_check #(.ALPHA(ALPHA)) u_check_a (
    .letter    (cfg_a),
    .is_onehot (a_onehot)
  );

  onehot_check #(.ALPHA(ALPHA)) u_check_b (
    .letter    (cfg_b),
    .is_onehot (b_onehot)
  );

  onehot_check #(.ALPHA(ALPHA)) u_check_in (
    .letter    (in_letter),
    .is_onehot (in_onehot)
  );

  // Config handshake and pair validation
  always_comb begin
    cfg_ready = (state_q == ST_LOAD) && (count_q < MAX_CNT) && !cfg_clear;
    offer     = cfg_valid && cfg_ready;
    reject    = !a_onehot || !b_onehot || (cfg_a == cfg_b) ||
                ((cfg_a & used_q) != '0) || ((cfg_b & used_q) != '0);
    write_en  = offer && !reject;
  end

  // State transitions; clear takes priority over lock
  always_comb begin
    state_d = state_q;
    if (cfg_clear) begin
      state_d = ST_LOAD;
    end else if ((state_q == ST_LOAD) && cfg_lock) begin
      state_d = ST_RUN;
    end
  end

  // Match the input against both sides of every slot and OR-reduce the partner.
  // Empty slots are zero, so they never match a one-hot letter.
  always_comb begin
    partner = '0;
    hit     = 1'b0;
    for (int i = 0; i < int'(MAX_PAIRS); i++) begin
      if (in_letter == slot_a_q[i]) begin
        partner = partner | slot_b_q[i];
        hit     = 1'b1;
      end
      if (in_letter == slot_b_q[i]) begin
        partner = partner | slot_a_q[i];
        hit     = 1'b1;
      end
    end
    lookup_letter = (in_onehot && hit) ? partner : in_letter;
  end

  // Configuration state: FSM, slot table, used mask, count, reject pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_LOAD;
      used_q    <= '0;
      count_q   <= '0;
      cfg_err_q <= 1'b0;
      for (int i = 0; i < int'(MAX_PAIRS); i++) begin
        slot_a_q[i] <= '0;
        slot_b_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cfg_err_q <= offer && reject;
      if (cfg_clear) begin
        used_q  <= '0;
        count_q <= '0;
        for (int i = 0; i < int'(MAX_PAIRS); i++) begin
          slot_a_q[i] <= '0;
          slot_b_q[i] <= '0;
        end
      end else if (write_en) begin
        used_q  <= used_q | cfg_a | cfg_b;
        count_q <= count_q + CW'(1);
        for (int i = 0; i < int'(MAX_PAIRS); i++) begin
          if (count_q == CW'(i)) begin
            slot_a_q[i] <= cfg_a;
            slot_b_q[i] <= cfg_b;
          end
        end
      end
    end
  end

  // Lookup pipeline register; letter and error hold when idle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_letter_q <= '0;
      out_err_q    <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        out_letter_q <= lookup_letter;
        out_err_q    <= !in_onehot;
      end
    end
  end

  // Output mapping
  always_comb begin
    cfg_err    = cfg_err_q;
    pair_count = count_q;
    locked     = (state_q == ST_RUN);
    out_valid  = out_valid_q;
    out_letter = out_letter_q;
    out_err    = out_err_q;
  end

endmodule

// File: tb/tb_stecker_board.sv
// Self-checking bench for stecker_board: a reference plugboard model predicts
// config responses each cycle and pushes lookup results to a scoreboard queue.
module tb_stecker_board;
  import enigma_pkg::*;

  localparam int unsigned NA = 26;
  localparam int unsigned NP = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          cfg_valid, cfg_lock, cfg_clear;
  logic          cfg_ready, cfg_err, locked;
  logic [NA-1:0] cfg_a, cfg_b;
  logic [3:0]    pair_count;
  logic          in_valid;
  logic [NA-1:0] in_letter;
  logic          out_valid, out_err;
  logic [NA-1:0] out_letter;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Scoreboard entries are {err, letter}
  logic [NA:0] exp_q [$];

  // Reference model
  logic [NA-1:0] m_part [NA];
  logic [NA-1:0] m_used;
  int            m_count;
  bit            m_locked;

  stecker_board #(.ALPHA(NA), .MAX_PAIRS(NP)) dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_a      (cfg_a),
    .cfg_b      (cfg_b),
    .cfg_lock   (cfg_lock),
    .cfg_clear  (cfg_clear),
    .cfg_err    (cfg_err),
    .pair_count (pair_count),
    .locked     (locked),
    .in_valid   (in_valid),
    .in_letter  (in_letter),
    .out_valid  (out_valid),
    .out_letter (out_letter),
    .out_err    (out_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NA-1:0] ltr(input int i);
    logic [NA-1:0] one;
    one = 1;
    return one << i;
  endfunction

  function automatic int idx_of(input logic [NA-1:0] l);
    int r;
    r = 0;
    for (int i = 0; i < int'(NA); i++) if (l[i]) r = i;
    return r;
  endfunction

  function automatic bit is_oh(input logic [NA-1:0] l);
    return $countones(l) == 1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < int'(NA); i++) m_part[i] = ltr(i);
    m_used  = '0;
    m_count = 0;
  endtask

  function automatic logic [NA:0] model_lookup(input logic [NA-1:0] l);
    if (!is_oh(l)) return {1'b1, l};
    return {1'b0, m_part[idx_of(l)]};
  endfunction

  // Compare each DUT output against the oldest predicted lookup
  always @(negedge clock) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'd1, 32'd0);
      end else begin
        logic [NA:0] e;
        e = exp_q.pop_front();
        check("out_letter", 32'(out_letter), 32'(e[NA-1:0]));
        check("out_err", 32'(out_err), 32'(e[NA]));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One clock of stimulus, with the model predicting every config response
  task automatic cycle(input bit cv, input logic [NA-1:0] a, input logic [NA-1:0] b,
                       input bit lock, input bit clr, input bit iv,
                       input logic [NA-1:0] il);
    bit exp_ready, exp_ok, exp_err;
    cfg_valid = cv; cfg_a = a; cfg_b = b; cfg_lock = lock; cfg_clear = clr;
    in_valid = iv; in_letter = il;
    exp_ready = !m_locked && (m_count < int'(NP)) && !clr;
    exp_ok = is_oh(a) && is_oh(b) && (a != b) && ((a & m_used) == '0) &&
             ((b & m_used) == '0);
    exp_err = cv && exp_ready && !exp_ok;
    #1;
    check("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
    if (iv) exp_q.push_back(model_lookup(il));
    tick();
    cfg_valid = 0; cfg_lock = 0; cfg_clear = 0; in_valid = 0;
    if (clr) begin
      model_clear();
      m_locked = 0;
    end else begin
      if (cv && exp_ready && exp_ok) begin
        m_part[idx_of(a)] = b;
        m_part[idx_of(b)] = a;
        m_used  = m_used | a | b;
        m_count++;
      end
      if (lock) m_locked = 1;
    end
    check("cfg_err", 32'(cfg_err), 32'(exp_err));
    check("pair_count", 32'(pair_count), 32'(m_count));
    check("locked", 32'(locked), 32'(m_locked));
  endtask

  task automatic look(input logic [NA-1:0] l);
    cycle(0, '0, '0, 0, 0, 1, l);
  endtask

  task automatic pair(input logic [NA-1:0] a, input logic [NA-1:0] b);
    cycle(1, a, b, 0, 0, 0, '0);
  endtask

  task automatic idle();
    cycle(0, '0, '0, 0, 0, 0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; cfg_valid = 0; cfg_a = '0; cfg_b = '0; cfg_lock = 0; cfg_clear = 0;
    in_valid = 0; in_letter = '0;
    model_clear();
    m_locked = 0;
    tick(); tick();
    reset = 0;
    #1;
    check("rst_pair_count", 32'(pair_count), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_letter", 32'(out_letter), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);

    // Empty board passes letters through, back to back
    look(LTR_E); look(LTR_Q); look(LTR_Z); idle();
    // out_valid drops and letter holds when idle
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("hold_out_letter", 32'(out_letter), 32'(LTR_Z));

    // Two pairs, lock, symmetric lookups
    pair(LTR_A, LTR_B); pair(LTR_C, LTR_D);
    cycle(0, '0, '0, 1, 0, 0, '0);
    look(LTR_A); look(LTR_B); look(LTR_C); look(LTR_E); idle();
    check("locked_after_lock", 32'(locked), 32'd1);
    // Offers in RUN are silently ignored
    pair(LTR_G, LTR_H);
    check("run_count", 32'(pair_count), 32'd2);

    // Clear from RUN, then rejected offers
    cycle(0, '0, '0, 0, 1, 0, '0);
    pair(LTR_A, LTR_B);
    pair(LTR_A, LTR_C);
    pair(LTR_F, LTR_F);
    pair('0, LTR_G);
    pair(LTR_H | LTR_I, LTR_J);
    check("rej_count", 32'(pair_count), 32'd1);
    look(LTR_C); look(LTR_B); idle();

    // Fill the table; the eleventh offer is ignored without error
    cycle(0, '0, '0, 0, 1, 0, '0);
    for (int i = 0; i < int'(NP); i++) pair(ltr(2 * i), ltr(2 * i + 1));
    check("full_ready", 32'(cfg_ready), 32'd0);
    pair(LTR_U, LTR_V);
    check("full_count", 32'(pair_count), 32'd10);
    look(LTR_T); look(LTR_S); look(LTR_U);
    // Lookup during clear still sees the old table
    cycle(0, '0, '0, 0, 1, 1, LTR_A);
    look(LTR_A); look(LTR_T); idle();

    // Lookup in the write cycle uses the pre-write table
    cycle(1, LTR_A, LTR_B, 0, 0, 1, LTR_A);
    look(LTR_A); look(LTR_A | LTR_B); look('0); idle();

    // Clear and lock together: clear wins
    cycle(0, '0, '0, 1, 1, 0, '0);
    check("clr_lock_locked", 32'(locked), 32'd0);
    check("clr_lock_count", 32'(pair_count), 32'd0);

    // Reset mid-stream
    pair(LTR_M, LTR_N);
    look(LTR_M); look(LTR_N); look(LTR_O);
    in_valid = 1; in_letter = LTR_M;
    #2;
    reset = 1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    exp_q.delete();
    in_valid = 0;
    model_clear();
    m_locked = 0;
    tick(); tick();
    reset = 0;
    #1;
    check("post_rst_count", 32'(pair_count), 32'd0);
    check("post_rst_ready", 32'(cfg_ready), 32'd1);
    look(LTR_M); look(LTR_N); idle(); idle();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stecker_board.md
Name: stecker_board

Overview:
- Clocked, parametrised Enigma plugboard (steckerbrett) that sits between keyboard input and the rotor/reflector stage.
- Letters are one-hot vectors of ALPHA bits.
- Up to MAX_PAIRS symmetric letter swaps are loaded through a ready/valid configuration port, validated, then locked.
- Lookups are pipelined with one-cycle latency and may run in either state.

Parameters:
ALPHA, 26, alphabet size = one-hot letter width
MAX_PAIRS, 10, maximum stored swap pairs (1..ALPHA/2)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cfg_valid  input  1  configuration pair offered
cfg_ready  output  1  block can accept a pair this cycle
cfg_a  input  ALPHA  first letter of pair, one-hot
cfg_b  input  ALPHA  second letter of pair, one-hot
cfg_lock  input  1  finish configuration, enter RUN
cfg_clear  input  1  erase all pairs, return to LOAD
cfg_err  output  1  one-cycle pulse: offered pair rejected
pair_count  output  $clog2(MAX_PAIRS+1)  number of stored pairs
locked  output  1  1 in RUN state
in_valid  input  1  letter to encode
in_letter  input  ALPHA  letter, one-hot
out_valid  output  1  encoded letter valid
out_letter  output  ALPHA  encoded letter, one-hot
out_err  output  1  accompanies out_valid: input was not one-hot

Behaviour:
- Reset (async assert, sync release) sets the following values:
  - state=LOAD
  - all pair slots and the used-letter mask cleared
  - pair_count=0, cfg_ready=1, cfg_err=0, locked=0
  - out_valid=0, out_letter=0, out_err=0
- FSM has two states, LOAD and RUN:
  - LOAD -> RUN on cfg_lock.
  - RUN -> LOAD on cfg_clear.
  - cfg_clear in LOAD also empties the table and stays in LOAD.
  - cfg_lock in RUN is ignored.
  - cfg_clear and cfg_lock in the same cycle: clear wins, giving LOAD with an empty table.
- cfg_ready = (state==LOAD) && (pair_count<MAX_PAIRS) && !cfg_clear.
- A pair is offered when cfg_valid && cfg_ready. The offered pair is rejected (cfg_err=1 next cycle, table unchanged) if any of these holds:
  - cfg_a is not one-hot, or cfg_b is not one-hot
  - cfg_a==cfg_b
  - cfg_a or cfg_b is already in the used mask
- An accepted pair is written to slot pair_count. The used mask ORs in cfg_a|cfg_b, and pair_count increments on the next edge.
- cfg_valid while cfg_ready=0 (RUN, or table full) is ignored silently, with no cfg_err.
- A table holds at most MAX_PAIRS pairs. Once full, cfg_ready=0 until clear or reset.
- Lookup, when in_valid is high:
  - Next cycle out_valid=1.
  - out_letter = partner letter if in_letter equals either side of any stored pair; otherwise out_letter=in_letter (pass-through).
  - Lookup is symmetric: A->B implies B->A.
  - A non-one-hot in_letter (zero or multi-bit) passes through unchanged with out_err=1.
  - When in_valid is low, out_valid=0 next cycle and out_letter/out_err hold their values.
- Lookup and config write in the same cycle: the lookup uses the pre-write table. A lookup in the cycle of cfg_clear uses the pre-clear table.
- Lookups are allowed in both states, with full throughput of one letter per cycle and no backpressure.
- Reset mid-stream: out_valid drops immediately (asynchronously), and the in-flight lookup is lost.

Decomposition:
- Package enigma_pkg holds:
  - ALPHA_DEFAULT=26 and PAIRS_DEFAULT=10
  - one-hot letter constants LTR_A..LTR_Z
  - the state enumeration (ST_LOAD, ST_RUN)
- Sub-module onehot_check: a combinational, parametrised ALPHA-bit one-hot detector, instantiated three times (cfg_a, cfg_b, in_letter).
- Slot storage and match/OR reduction stay in stecker_board.

Test Plan:
- Reset, then drive E,Q,Z with in_valid -> out_letter E,Q,Z one cycle later; out_err=0; pair_count=0.
- Load A-B, C-D, lock, then drive A,B,C,E -> outputs B,A,D,E; pair_count=2; locked=1.
- Offer A-C after A-B; then offer F-F; then offer 0-G -> cfg_err pulses each time; pair_count stays 1; lookup of C returns C.
- Load 10 valid pairs -> cfg_ready=0; an 11th cfg_valid is ignored, with no cfg_err and count=10. Then cfg_clear -> count=0, locked=0, all letters pass through.
- Drive in_letter=A in the same cycle pair A-B is accepted -> output A (pre-write table). The next lookup of A gives B. Multi-bit input A|B -> passed through with out_err=1.
- Assert reset mid-stream after 3 lookups -> out_valid=0 immediately; after release the table is empty and cfg_ready=1.
